// File: rtl/axi4_rd_sram_ctrl.sv
// AXI4 read-only slave that turns AR bursts into single-cycle-latency SRAM word reads.
// One burst at a time; beats are buffered in a 2-entry FIFO so R backpressure never
// drops data. Error bursts still produce arlen+1 paced beats but never touch the SRAM.
module axi4_rd_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned OFF = $clog2(DATA_WIDTH / 8);
  localparam int unsigned HI  = OFF + MEM_AW;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e                state_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [8:0]            issued_q;
  logic                  infl_q;
  logic                  infl_last_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [1:0]            fifo_resp_q [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;

  logic                  ar_err;
  logic [2:0]            occ;
  logic                  rvalid_int;
  logic                  pop;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_w;
  logic [ADDR_WIDTH-1:0] wrap_lo;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Legality of the incoming AR request, evaluated at capture time only.
  always_comb begin
    ar_err = 1'b0;
    if (arsize > 3'(OFF)) ar_err = 1'b1;
    if (arburst == 2'd3) ar_err = 1'b1;
    if (arburst == 2'd2 && !(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15)) begin
      ar_err = 1'b1;
    end
    if ((araddr >> HI) != '0) ar_err = 1'b1;
  end

  // Issue decision: a slot is free if occupancy < 2, or becomes free via this cycle's pop.
  always_comb begin
    rvalid_int = (cnt_q != 2'd0);
    pop        = aresetn && rvalid_int && rready;
    occ        = 3'(cnt_q) + 3'(infl_q);
    issue      = aresetn && (state_q == StBurst) && (issued_q <= {1'b0, len_q}) &&
                 ((occ < 3'd2) || ((occ == 3'd2) && pop));
  end

  // Beat address sequencing for FIXED / INCR / WRAP.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_w    = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    wrap_lo   = addr_q & ~(wrap_w - ADDR_WIDTH'(1));
    seq_addr  = addr_q + step;
    next_addr = addr_q;
    case (burst_q)
      2'd1:    next_addr = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
      2'd2:    next_addr = (seq_addr == wrap_lo + wrap_w) ? wrap_lo : seq_addr;
      default: next_addr = addr_q;
    endcase
  end

  // Outputs are forced to zero while reset is asserted.
  assign arready  = aresetn && (state_q == StIdle);
  assign rvalid   = aresetn && rvalid_int;
  assign rdata    = rvalid ? fifo_data_q[rd_ptr_q] : '0;
  assign rresp    = rvalid ? fifo_resp_q[rd_ptr_q] : 2'b00;
  assign rlast    = rvalid && fifo_last_q[rd_ptr_q];
  assign rid      = aresetn ? id_q : '0;
  assign mem_en   = issue && !err_q;
  assign mem_addr = aresetn ? addr_q[HI-1:OFF] : '0;

  // FSM, burst counters, in-flight tracking and the 2-entry R FIFO.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      id_q           <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      size_q         <= '0;
      burst_q        <= '0;
      err_q          <= 1'b0;
      issued_q       <= '0;
      infl_q         <= 1'b0;
      infl_last_q    <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_resp_q[0] <= '0;
      fifo_resp_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arvalid) begin
            id_q     <= arid;
            addr_q   <= araddr;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= arburst;
            err_q    <= ar_err;
            issued_q <= '0;
            state_q  <= StBurst;
          end
        end
        StBurst: begin
          if (issue) begin
            addr_q      <= next_addr;
            issued_q    <= issued_q + 9'd1;
            infl_last_q <= (issued_q == {1'b0, len_q});
          end
          infl_q <= issue;
          // SRAM data (or zero data for an error burst) lands one cycle after the issue.
          if (infl_q) begin
            fifo_data_q[wr_ptr_q] <= err_q ? '0 : mem_rdata;
            fifo_resp_q[wr_ptr_q] <= err_q ? 2'b10 : 2'b00;
            fifo_last_q[wr_ptr_q] <= infl_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
          end
          if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
            if (fifo_last_q[rd_ptr_q]) state_q <= StIdle;
          end
          cnt_q <= cnt_q + 2'(infl_q) - 2'(pop);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/axi4_rd_sram_ctrl.md
# axi4_rd_sram_ctrl

AXI4 read-only slave controller sitting directly downstream of an `axi4_if` slave-side read channel (AR/R). It converts accepted read bursts into single-cycle-latency SRAM word reads. It generates FIXED/INCR/WRAP beat addresses and buffers returned data in a 2-entry output FIFO, so `rready` backpressure never loses a beat. One burst is handled at a time, with full one-beat-per-cycle throughput when `rready` is held high.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 64, AXI/SRAM data width (power of 2, ≥16)
- ID_WIDTH, 4, AXI ID width
- MEM_AW, 10, SRAM word-address width (depth 2^MEM_AW words)
- aclk  in  1  clock; one clock domain, everything on posedge
- aresetn  in  1  synchronous active-low reset
- arid  in  ID_WIDTH  read ID
- araddr  in  ADDR_WIDTH  start byte address
- arlen  in  8  beats−1
- arsize  in  3  bytes/beat = 2^arsize
- arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  ID_WIDTH  echoed arid
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rlast  out  1  final beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- mem_en  out  1  SRAM read strobe
- mem_addr  out  MEM_AW  SRAM word address
- mem_rdata  in  DATA_WIDTH  SRAM data, valid the cycle after mem_en

## Operation
- FSM states: IDLE, BURST. `arready` = 1 only in IDLE. An AR handshake captures id/addr/len/size/burst and moves the FSM to BURST.
- Error check at capture; any failure makes the burst an error burst:
  - arsize > log2(DATA_WIDTH/8)
  - arburst == 3
  - WRAP with arlen not in {1,3,7,15}
  - araddr bits above byte-offset+MEM_AW nonzero
- Error burst: arlen+1 beats with rresp=10 and rdata=0. `mem_en` is never asserted. Pacing goes through the same FIFO path.
- Beat address:
  - Word index = addr[log2(DATA_WIDTH/8)+MEM_AW−1 : log2(DATA_WIDTH/8)].
  - FIXED: addr is constant.
  - INCR: next = (addr aligned to 2^size) + 2^size, modulo 2^(MEM_AW) words. There is no 4KB check.
  - WRAP: W = (len+1)<<size, lower = addr & ~(W−1). next = addr+2^size, replaced by lower when it equals lower+W.
- Narrow beats return the full SRAM word; the master selects lanes.
- Occupancy = FIFO entries + reads in flight (0/1), max 2. Issue a read (mem_en=1) while beats issued ≤ arlen and (occupancy < 2, or occupancy == 2 with an R handshake this cycle).
- FIFO entry holds {rdata, rresp, rlast}. rlast is set on beat index arlen. `rid` = captured ID.
- Return to IDLE on the R handshake with rlast=1. `arready` is 1 in the following cycle.

## Timing
- Reset (aresetn low at posedge): state IDLE, FIFO empty, in-flight cleared, counters 0. Outputs while in reset: arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, rid=0, mem_en=0, mem_addr=0. arready=1 in the first cycle after release.
- Reset mid-burst aborts immediately. In-flight SRAM data is discarded and no further R beats are produced.
- AR handshake at edge E0: mem_en=1 in cycle after E0 (cycle 1). mem_rdata is valid in cycle 2 and written to the FIFO at the end of cycle 2. First rvalid is in cycle 3.
- With rready constantly 1: one beat per cycle; last beat at cycle 3+arlen; arready back at cycle 4+arlen.
- rvalid/rdata/rresp/rlast/rid hold stable while rvalid && !rready.
- FIFO full with no R handshake: mem_en=0. Simultaneous push and pop keeps count unchanged.
- arvalid arriving during BURST is held off (arready=0) and not sampled.

## Test plan
- INCR araddr=0x100, arlen=3, arsize=3, rready=1 → mem_addr 0x20,0x21,0x22,0x23 on consecutive cycles. R beats in cycles 3–6, rlast on 4th, rresp=00, rid echoed.
- WRAP araddr=0x118, arlen=3, arsize=3 → mem_addr 0x23,0x20,0x21,0x22. FIXED araddr=0x40, arlen=2 → 0x08 three times.
- INCR arlen=7, rready toggling 1,0,0,1,… → all 8 beats delivered in address order with no loss or duplication. mem_en never asserted while occupancy=2 without a pop. R signals stable while stalled.
- Errors: arsize=4 (64-bit bus), arburst=3, WRAP arlen=2, araddr=0x2000 (MEM_AW=10) → each gives arlen+1 beats with rresp=10 and rdata=0. mem_en stays 0 throughout.
- aresetn low for one cycle mid-way through an arlen=15 burst → rvalid=0 the next cycle, no further beats, arready=1 after release. A new burst completes normally.
